// File: rtl/load_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_fwd_hazard_unit
//  Description : Load forwarding and hazard control for a 5-stage pipeline.
//                Keeps a shadow copy of the destination registers in flight
//                in EX, MEM and WB.
//                Drives four 1-bit selects that pick memory-read data over
//                decode data for the ID and EX operands.
//                Raises a stall for load-use and branch-on-load hazards.
//                Counts stalled cycles in a saturating counter.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock, all state updates on rising edge
//    rst          in   synchronous reset, active-high
//    id_valid     in   ID holds a real instruction
//    id_rs/id_rt  in   ID source registers
//    id_use_rs/rt in   ID instruction reads rs / rt
//    id_branch    in   ID instruction resolves a branch in ID
//    id_we        in   ID instruction writes a register
//    id_wr        in   ID destination register
//    id_load      in   ID instruction is a load
//    fwd_id_rs/rt out  ID rs/rt take memory-read data
//    fwd_ex_rs/rt out  EX rs/rt take memory-read data
//    stall        out  hold PC/IF/ID, inject bubble into EX
//    stall_count  out  saturating count of stalled cycles
// ============================================================================
module load_fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_branch,
  input  logic              id_we,
  input  logic [REG_AW-1:0] id_wr,
  input  logic              id_load,
  output logic              fwd_id_rs,
  output logic              fwd_id_rt,
  output logic              fwd_ex_rs,
  output logic              fwd_ex_rt,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  // EX shadow slot
  logic [REG_AW-1:0] r_ex_rs;
  logic [REG_AW-1:0] r_ex_rt;
  logic              r_ex_use_rs;
  logic              r_ex_use_rt;
  logic              r_ex_we;
  logic [REG_AW-1:0] r_ex_wr;
  logic              r_ex_load;

  // MEM and WB shadow slots
  logic              r_mem_we;
  logic [REG_AW-1:0] r_mem_wr;
  logic              r_mem_load;
  logic              r_wb_we;
  logic [REG_AW-1:0] r_wb_wr;
  logic              r_wb_load;

  logic [CNT_W-1:0]  r_stall_count;

  // Qualified ID fields. A write to register 0 is dropped here, so no
  // downstream slot can ever match on r0.
  logic w_id_we;
  logic w_id_use_rs;
  logic w_id_use_rt;
  logic w_id_load;

  logic w_dep_ex;
  logic w_dep_mem;
  logic w_load_use;
  logic w_branch_on_load;
  logic w_stall;
  logic w_wb_load_wr;

  assign w_id_we     = id_valid & id_we & (id_wr != '0);
  assign w_id_use_rs = id_valid & id_use_rs;
  assign w_id_use_rt = id_valid & id_use_rt;
  assign w_id_load   = id_valid & id_load;

  // Producer in EX / MEM is a load whose result the ID instruction reads.
  assign w_dep_ex  = r_ex_we & r_ex_load &
                     ((id_use_rs & (r_ex_wr == id_rs)) |
                      (id_use_rt & (r_ex_wr == id_rt)));
  assign w_dep_mem = r_mem_we & r_mem_load &
                     ((id_use_rs & (r_mem_wr == id_rs)) |
                      (id_use_rt & (r_mem_wr == id_rt)));

  // A load in EX blocks any consumer; a load in MEM only blocks a branch,
  // since a branch needs its operands one stage earlier.
  assign w_load_use       = id_valid & w_dep_ex;
  assign w_branch_on_load = id_valid & id_branch & w_dep_mem;
  assign w_stall          = w_load_use | w_branch_on_load;

  // Only loads in WB feed the memory-read path; ALU results in WB are
  // forwarded elsewhere.
  assign w_wb_load_wr = r_wb_we & r_wb_load;

  assign fwd_ex_rs = r_ex_use_rs & w_wb_load_wr & (r_wb_wr == r_ex_rs);
  assign fwd_ex_rt = r_ex_use_rt & w_wb_load_wr & (r_wb_wr == r_ex_rt);
  assign fwd_id_rs = id_valid & id_use_rs & w_wb_load_wr & (r_wb_wr == id_rs);
  assign fwd_id_rt = id_valid & id_use_rt & w_wb_load_wr & (r_wb_wr == id_rt);

  assign stall       = w_stall;
  assign stall_count = r_stall_count;

  // Shadow pipeline: MEM and WB advance every cycle; EX takes a bubble
  // while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_rs     <= '0;
      r_ex_rt     <= '0;
      r_ex_use_rs <= 1'b0;
      r_ex_use_rt <= 1'b0;
      r_ex_we     <= 1'b0;
      r_ex_wr     <= '0;
      r_ex_load   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wr    <= '0;
      r_mem_load  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_wr     <= '0;
      r_wb_load   <= 1'b0;
    end else begin
      r_wb_we    <= r_mem_we;
      r_wb_wr    <= r_mem_wr;
      r_wb_load  <= r_mem_load;
      r_mem_we   <= r_ex_we;
      r_mem_wr   <= r_ex_wr;
      r_mem_load <= r_ex_load;
      if (w_stall) begin
        r_ex_rs     <= '0;
        r_ex_rt     <= '0;
        r_ex_use_rs <= 1'b0;
        r_ex_use_rt <= 1'b0;
        r_ex_we     <= 1'b0;
        r_ex_wr     <= '0;
        r_ex_load   <= 1'b0;
      end else begin
        r_ex_rs     <= id_rs;
        r_ex_rt     <= id_rt;
        r_ex_use_rs <= w_id_use_rs;
        r_ex_use_rt <= w_id_use_rt;
        r_ex_we     <= w_id_we;
        r_ex_wr     <= id_wr;
        r_ex_load   <= w_id_load;
      end
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_fwd_hazard_unit
//  Description : Directed scoreboard bench for load_fwd_hazard_unit. A
//                16-bit-counter instance and a 3-bit-counter instance share
//                the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_fwd_hazard_unit;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_branch;
  logic       id_we;
  logic [4:0] id_wr;
  logic       id_load;

  logic        fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt, stall;
  logic [15:0] stall_count;
  logic        s_fwd_id_rs, s_fwd_id_rt, s_fwd_ex_rs, s_fwd_ex_rt, s_stall;
  logic [2:0]  s_stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  load_fwd_hazard_unit #(.REG_AW(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
    .id_we(id_we), .id_wr(id_wr), .id_load(id_load),
    .fwd_id_rs(fwd_id_rs), .fwd_id_rt(fwd_id_rt),
    .fwd_ex_rs(fwd_ex_rs), .fwd_ex_rt(fwd_ex_rt),
    .stall(stall), .stall_count(stall_count)
  );

  load_fwd_hazard_unit #(.REG_AW(5), .CNT_W(3)) u_dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
    .id_we(id_we), .id_wr(id_wr), .id_load(id_load),
    .fwd_id_rs(s_fwd_id_rs), .fwd_id_rt(s_fwd_id_rt),
    .fwd_ex_rs(s_fwd_ex_rs), .fwd_ex_rt(s_fwd_ex_rt),
    .stall(s_stall), .stall_count(s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk;
    logic        stall;
    logic [3:0]  fwd;   // {id_rs, id_rt, ex_rs, ex_rt}
    logic [15:0] cnt;
    logic [2:0]  sat;
  } exp_t;

  exp_t q[$];
  exp_t m_e;

  // ---------------- stimulus helpers ----------------
  task automatic set_fields(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic urs, input logic urt, input logic br,
                            input logic we, input logic [4:0] wr, input logic ld);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_branch = br; id_we = we; id_wr = wr; id_load = ld;
  endtask

  task automatic set_nop();
    set_fields(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask
  task automatic set_lw(input logic [4:0] wr, input logic [4:0] base);
    set_fields(1'b1, base, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, wr, 1'b1);
  endtask
  task automatic set_alu(input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt);
    set_fields(1'b1, rs, rt, 1'b1, 1'b1, 1'b0, 1'b1, wr, 1'b0);
  endtask
  task automatic set_br(input logic [4:0] rs, input logic [4:0] rt);
    set_fields(1'b1, rs, rt, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  // Push the expected outputs for the current cycle, then advance a cycle.
  task automatic step(input logic chk, input logic e_stall, input logic [3:0] e_fwd,
                      input int e_cnt);
    exp_t e;
    e.chk   = chk;
    e.stall = e_stall;
    e.fwd   = e_fwd;
    e.cnt   = 16'(e_cnt);
    e.sat   = (e_cnt > 7) ? 3'd7 : 3'(e_cnt);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      if (m_e.chk) begin
        cmp("stall", 16'(stall), 16'(m_e.stall));
        cmp("fwd", 16'({fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt}), 16'(m_e.fwd));
        cmp("stall_count", stall_count, m_e.cnt);
        cmp("stall_count_sat", 16'(s_stall_count), 16'(m_e.sat));
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    set_fields(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1);
    @(posedge clk); #1;
    // second reset cycle with different junk: state already cleared
    set_fields(1'b1, 5'd7, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1);
    step(1, 0, 4'b0000, 0);
    rst = 1'b0;
    set_nop();             step(1, 0, 4'b0000, 0);

    // load-use: lw r8 ; add r9,r8,r10
    set_lw(5'd8, 5'd2);    step(1, 0, 4'b0000, 0);
    set_alu(5'd9, 5'd8, 5'd10);
                           step(1, 1, 4'b0000, 0);
                           step(1, 0, 4'b0000, 1);
    set_nop();             step(1, 0, 4'b0010, 1);
                           step(1, 0, 4'b0000, 1);
                           step(1, 0, 4'b0000, 1);

    // branch-on-load: lw r5 ; beq r5,r6
    set_lw(5'd5, 5'd29);   step(1, 0, 4'b0000, 1);
    set_br(5'd5, 5'd6);    step(1, 1, 4'b0000, 1);
                           step(1, 1, 4'b0000, 2);
                           step(1, 0, 4'b1000, 3);
    set_nop();             step(1, 0, 4'b0000, 3);
                           step(1, 0, 4'b0000, 3);

    // same load on both operands: lw r12 ; and r13,r12,r12
    set_lw(5'd12, 5'd1);   step(1, 0, 4'b0000, 3);
    set_alu(5'd13, 5'd12, 5'd12);
                           step(1, 1, 4'b0000, 3);
                           step(1, 0, 4'b0000, 4);
    set_nop();             step(1, 0, 4'b0011, 4);
                           step(1, 0, 4'b0000, 4);

    // branch on both operands: lw r14 ; beq r14,r14
    set_lw(5'd14, 5'd1);   step(1, 0, 4'b0000, 4);
    set_br(5'd14, 5'd14);  step(1, 1, 4'b0000, 4);
                           step(1, 1, 4'b0000, 5);
                           step(1, 0, 4'b1100, 6);
    set_nop();             step(1, 0, 4'b0000, 6);
                           step(1, 0, 4'b0000, 6);

    // zero register: lw r0 ; add r1,r0,r0 ; nop ; beq r0,r0
    set_lw(5'd0, 5'd2);    step(1, 0, 4'b0000, 6);
    set_alu(5'd1, 5'd0, 5'd0);
                           step(1, 0, 4'b0000, 6);
    set_nop();             step(1, 0, 4'b0000, 6);
    set_br(5'd0, 5'd0);    step(1, 0, 4'b0000, 6);
    set_nop();             step(1, 0, 4'b0000, 6);

    // non-load producer: add r4 ; nop ; sub r7,r4,r4 ; beq r4,r4
    set_alu(5'd4, 5'd1, 5'd2);
                           step(1, 0, 4'b0000, 6);
    set_nop();             step(1, 0, 4'b0000, 6);
    set_alu(5'd7, 5'd4, 5'd4);
                           step(1, 0, 4'b0000, 6);
    set_br(5'd4, 5'd4);    step(1, 0, 4'b0000, 6);
    set_nop();             step(1, 0, 4'b0000, 6);

    // invalid ID slots carrying hazard-looking fields never matter
    set_lw(5'd20, 5'd1);   step(1, 0, 4'b0000, 6);
    set_fields(1'b0, 5'd20, 5'd20, 1'b1, 1'b1, 1'b1, 1'b1, 5'd20, 1'b1);
                           step(1, 0, 4'b0000, 6);
                           step(1, 0, 4'b0000, 6);
                           step(1, 0, 4'b0000, 6);
    set_alu(5'd21, 5'd20, 5'd20);
                           step(1, 0, 4'b0000, 6);
    set_nop();             step(1, 0, 4'b0000, 6);
                           step(1, 0, 4'b0000, 6);

    // reset during first stall cycle of a branch-on-load
    set_lw(5'd5, 5'd29);   step(1, 0, 4'b0000, 6);
    set_br(5'd5, 5'd6);
    rst = 1'b1;            step(1, 1, 4'b0000, 6);
    rst = 1'b0;            step(1, 0, 4'b0000, 0);
                           step(1, 0, 4'b0000, 0);
                           step(1, 0, 4'b0000, 0);
    set_nop();             step(1, 0, 4'b0000, 0);

    // saturation: five branch-on-load sequences, 10 stall cycles
    for (int k = 0; k < 5; k++) begin
      set_lw(5'd5, 5'd29); step(1, 0, 4'b0000, 2*k);
      set_br(5'd5, 5'd6);  step(1, 1, 4'b0000, 2*k);
                           step(1, 1, 4'b0000, 2*k + 1);
                           step(1, 0, 4'b1000, 2*k + 2);
    end
    set_nop();             step(1, 0, 4'b0000, 10);
                           step(1, 0, 4'b0000, 10);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_fwd_hazard_unit.md
Name: load_fwd_hazard_unit

Overview:
- Control block sitting directly upstream of the memory-read forwarding selectors for the ID and EX stages.
- Tracks in-flight destination registers across EX, MEM and WB, and drives the four 1-bit forward selects (ID rs/rt, EX rs/rt) that choose memory-read data over decode data.
- Raises a stall for load-use and branch-on-load hazards that forwarding cannot cover.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_AW, 5, register address width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_AW  ID source register rs
- id_rt  in  REG_AW  ID source register rt
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_branch  in  1  ID instruction resolves a branch in ID (operands needed in ID)
- id_we  in  1  ID instruction writes a register
- id_wr  in  REG_AW  ID destination register
- id_load  in  1  ID instruction is a load
- fwd_id_rs  out  1  ID rs takes memory-read data
- fwd_id_rt  out  1  ID rt takes memory-read data
- fwd_ex_rs  out  1  EX rs takes memory-read data
- fwd_ex_rt  out  1  EX rt takes memory-read data
- stall  out  1  hold PC/IF/ID, inject bubble into EX
- stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Internal shadow pipeline:
  - EX slot: rs, rt, use_rs, use_rt, we, wr, load.
  - MEM slot and WB slot: we, wr, load.
- Every clock (pipeline never frozen beyond stall): WB<=MEM, MEM<=EX.
- EX slot load:
  - When stall=0: EX<=ID fields, qualified by id_valid; we, load, use_* are forced to 0 when id_valid=0.
  - When stall=1: EX is loaded with a bubble (all flags 0).
- Register 0 never creates a hazard or a forward (wr==0 treated as we=0).
- Forward selects are combinational from current state plus ID inputs; no added latency:
  - fwd_ex_rs = EX.use_rs & WB.we & WB.load & WB.wr==EX.rs; same form for rt.
  - fwd_id_rs = id_valid & id_use_rs & WB.we & WB.load & WB.wr==id_rs; same form for rt.
  - Non-load writes in WB never assert these selects; they belong to the ALU forwarding path.
- Hazard terms, with dep(slot) = slot.we & slot.load & (id_use_rs & slot.wr==id_rs | id_use_rt & slot.wr==id_rt):
  - Load-use: id_valid & dep(EX).
  - Branch-on-load: id_valid & id_branch & dep(MEM). An EX dependency is already covered by load-use.
  - stall = load-use | branch-on-load.
- Resulting stall lengths:
  - Plain ALU consumer of a load: 1 stall cycle, then fwd_ex_* asserts while the load is in WB.
  - Branch consumer: 2 stall cycles, then fwd_id_* asserts.
- Consumer read both rs and rt from the same load: single stall sequence; both selects assert together.
- stall_count: +1 on every cycle with stall=1; holds at all-ones (no wrap).
- Reset values:
  - All shadow slots cleared (we, load, use_* = 0; addresses = 0).
  - stall_count=0.
  - As a consequence, all forward selects and stall read 0 in the cycle after reset.
- Reset mid-stall: the stall drops in the cycle after reset is sampled; in-flight loads are discarded and no forward is emitted for them.
- Inputs with id_valid=0 never cause stall or fwd_id_*.

Test Plan:
- Reset: hold rst 2 cycles with junk on inputs -> stall, all fwd_* = 0, stall_count=0.
- Load-use: issue lw r8 then add r9,r8,r10 -> stall=1 for exactly 1 cycle; 2 cycles later fwd_ex_rs=1, fwd_ex_rt=0; stall_count=1.
- Branch-on-load: issue lw r5 then beq r5,r6 -> stall=1 for 2 consecutive cycles, then fwd_id_rs=1 for 1 cycle; stall_count=2.
- Zero register: issue lw r0 then add r1,r0,r0 -> no stall, no forward.
- Non-load producer: issue add r4 then sub r7,r4,r4 -> no stall; no fwd_* asserted at any point.
- Saturation and reset mid-stall:
  - With CNT_W=3, sustain 9 stall cycles -> stall_count holds 7.
  - Assert rst during the first stall cycle of a branch-on-load -> stall=0 next cycle, no later fwd_id_*.
